// File: rtl/deserializer_serial_input_parallel_output_pkg.sv
// Shared definitions for the serial shift path: FSM state encodings and bit-counter width.
package deserializer_serial_input_parallel_output_pkg;

  localparam int unsigned CNT_W = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/deserializer_serial_input_parallel_output_sipo_shift_core.sv
// Shift register and bit counter for the SIPO receiver; LSB-first, newest bit enters at the top.
module sipo_shift_core
  import deserializer_serial_input_parallel_output_pkg::*;
#(
  parameter int unsigned SIZE = 12
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic             last_c,
  output logic [SIZE:1]    word_c
);

  logic [SIZE:1]    shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // word_c is the value the register holds after this shift; on the last bit it is the full word
  assign word_c    = {bit_i, shift_q[SIZE:2]};
  assign last_c    = (cnt_q == CNT_W'(SIZE - 1));
  assign bit_cnt_o = cnt_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_i) begin
      shift_d = word_c;
      cnt_d   = last_c ? '0 : CNT_W'(cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/deserializer_serial_input_parallel_output.sv
// SIPO receiver: frames serial bits into words, holds the last word behind a valid/ack handshake.
module deserializer_serial_input_parallel_output
  import deserializer_serial_input_parallel_output_pkg::*;
#(
  parameter int unsigned SIZE       = 12,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             shift_en,
  input  logic             data_in,
  input  logic             rd_ack,
  output logic [SIZE:1]    data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  state_e        state_q, state_d;
  logic [SIZE:1] data_out_q, data_out_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          core_clear, core_shift, core_last_c;
  logic [SIZE:1] core_word_c;

  sipo_shift_core #(.SIZE(SIZE)) u_core (
    .clk       (clk),
    .clr       (clr),
    .clear_i   (core_clear),
    .shift_i   (core_shift),
    .bit_i     (data_in),
    .bit_cnt_o (bit_cnt),
    .last_c    (core_last_c),
    .word_c    (core_word_c)
  );

  // Framing FSM plus holding register; start always wins over shift_en
  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    core_clear = 1'b0;
    core_shift = 1'b0;

    if (rd_ack && valid_q) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SHIFT;
          core_clear = 1'b1;
          ovr_d      = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          core_clear = 1'b1;
          ovr_d      = 1'b0;
        end else if (shift_en) begin
          core_shift = 1'b1;
          if (core_last_c) begin
            data_out_d = core_word_c;
            valid_d    = 1'b1;
            if (valid_q && !rd_ack) ovr_d = 1'b1;
            if (!CONTINUOUS) state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_deserializer_serial_input_parallel_output.sv
// Bench: one-shot and continuous receivers share stimulus; each is checked against a word-level model.
module tb_deserializer_serial_input_parallel_output;

  localparam int SIZE = 12;

  logic clk, clr, start, shift_en, data_in, rd_ack;
  logic [SIZE:1] out0, out1;
  logic          val0, val1, busy0, busy1, ovr0, ovr1;
  logic [5:0]    cnt0, cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  deserializer_serial_input_parallel_output #(.SIZE(SIZE), .CONTINUOUS(1'b0)) dut0 (
    .clk(clk), .clr(clr), .start(start), .shift_en(shift_en), .data_in(data_in),
    .rd_ack(rd_ack), .data_out(out0), .data_valid(val0), .busy(busy0),
    .overrun(ovr0), .bit_cnt(cnt0));

  deserializer_serial_input_parallel_output #(.SIZE(SIZE), .CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .clr(clr), .start(start), .shift_en(shift_en), .data_in(data_in),
    .rd_ack(rd_ack), .data_out(out1), .data_valid(val1), .busy(busy1),
    .overrun(ovr1), .bit_cnt(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: bits accumulate by position index into an integer word
  bit            m_busy[2], m_valid[2], m_ovr[2];
  int            m_cnt[2];
  logic [SIZE:1] m_word[2], m_out[2];

  task automatic model_step(input int i, input bit cont);
    bit ack_clr;
    ack_clr = rd_ack && m_valid[i];
    if (start) begin
      m_busy[i] = 1'b1;
      m_cnt[i]  = 0;
      m_word[i] = '0;
      m_ovr[i]  = 1'b0;
      if (ack_clr) m_valid[i] = 1'b0;
    end else if (m_busy[i] && shift_en) begin
      if (m_cnt[i] == SIZE - 1) begin
        m_out[i] = m_word[i] | (SIZE'(data_in) << (SIZE - 1));
        if (m_valid[i] && !rd_ack) m_ovr[i] = 1'b1;
        m_valid[i] = 1'b1;
        m_cnt[i]   = 0;
        m_word[i]  = '0;
        m_busy[i]  = cont;
      end else begin
        m_word[i] = m_word[i] | (SIZE'(data_in) << m_cnt[i]);
        m_cnt[i]  = m_cnt[i] + 1;
        if (ack_clr) m_valid[i] = 1'b0;
      end
    end else if (ack_clr) begin
      m_valid[i] = 1'b0;
    end
  endtask

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_ovr[i] = 1'b0;
        m_cnt[i] = 0; m_word[i] = '0; m_out[i] = '0;
      end
    end else begin
      model_step(0, 1'b0);
      model_step(1, 1'b1);
    end
  end

  // Every falling edge: both DUTs against the model
  always @(negedge clk) begin
    chk("d0_out",   32'(out0),  32'(m_out[0]));
    chk("d0_valid", 32'(val0),  32'(m_valid[0]));
    chk("d0_busy",  32'(busy0), 32'(m_busy[0]));
    chk("d0_ovr",   32'(ovr0),  32'(m_ovr[0]));
    chk("d0_cnt",   32'(cnt0),  32'(m_cnt[0]));
    chk("d1_out",   32'(out1),  32'(m_out[1]));
    chk("d1_valid", 32'(val1),  32'(m_valid[1]));
    chk("d1_busy",  32'(busy1), 32'(m_busy[1]));
    chk("d1_ovr",   32'(ovr1),  32'(m_ovr[1]));
    chk("d1_cnt",   32'(cnt1),  32'(m_cnt[1]));
  end

  task automatic cyc(input bit s, input bit se, input bit d, input bit a);
    @(posedge clk);
    #1;
    start = s; shift_en = se; data_in = d; rd_ack = a;
  endtask

  task automatic send_bits(input logic [SIZE-1:0] w, input int lo, input int hi,
                           input int maxgap, input bit ack_last);
    for (int i = lo; i <= hi; i++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) cyc(1'b0, 1'b0, 1'($urandom), 1'b0);
      cyc(1'b0, 1'b1, w[i], ack_last && (i == hi));
    end
  endtask

  task automatic idle1();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ack1();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; shift_en = 1'b0; data_in = 1'b0; rd_ack = 1'b0;
    #1 clr = 1'b1;
    #1;
    chk("rst_out", 32'(out0), 32'h0);
    chk("rst_valid", 32'(val0), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_cnt", 32'(cnt1), 32'h0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    // 1: back-to-back bits
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(12'hA5C, 0, SIZE - 1, 0, 1'b0);
    idle1();
    chk("t1_out", 32'(out0), 32'hA5C);
    chk("t1_valid", 32'(val0), 32'h1);
    chk("t1_busy", 32'(busy0), 32'h0);
    chk("t1_cnt", 32'(cnt0), 32'h0);
    chk("t1_busy_cont", 32'(busy1), 32'h1);
    ack1();
    idle1();
    chk("t1_ack", 32'(val0), 32'h0);

    // 2: gaps, with bit_cnt holding across an idle stretch
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(12'hA5C, 0, 4, 3, 1'b0);
    repeat (3) begin
      idle1();
      chk("t2_hold", 32'(cnt0), 32'd5);
    end
    send_bits(12'hA5C, 5, SIZE - 1, 3, 1'b0);
    idle1();
    chk("t2_out", 32'(out0), 32'hA5C);
    ack1();

    // 3: continuous overrun, then acked completion
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(12'h123, 0, SIZE - 1, 1, 1'b0);
    send_bits(12'hFED, 0, SIZE - 1, 1, 1'b0);
    idle1();
    chk("t3_out", 32'(out1), 32'hFED);
    chk("t3_ovr", 32'(ovr1), 32'h1);
    chk("t3_out_oneshot", 32'(out0), 32'h123);
    chk("t3_ovr_oneshot", 32'(ovr0), 32'h0);
    ack1();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(12'h123, 0, SIZE - 1, 0, 1'b0);
    send_bits(12'hFED, 0, SIZE - 1, 0, 1'b1);
    idle1();
    chk("t3b_out", 32'(out1), 32'hFED);
    chk("t3b_ovr", 32'(ovr1), 32'h0);
    chk("t3b_valid", 32'(val1), 32'h1);
    ack1();

    // 4: restart drops a partial word
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(12'hFFF, 0, 4, 0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    send_bits(12'h0F0, 0, SIZE - 1, 2, 1'b0);
    idle1();
    chk("t4_out", 32'(out0), 32'h0F0);
    chk("t4_out_cont", 32'(out1), 32'h0F0);
    ack1();

    // 5: asynchronous clear mid-word
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(12'h5AF, 0, 6, 0, 1'b0);
    idle1();
    #2 clr = 1'b1;
    #1;
    chk("t5_out", 32'(out0), 32'h0);
    chk("t5_valid", 32'(val1), 32'h0);
    chk("t5_busy", 32'(busy0), 32'h0);
    chk("t5_cnt", 32'(cnt1), 32'h0);
    chk("t5_ovr", 32'(ovr1), 32'h0);
    #1 clr = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(12'h3C9, 0, SIZE - 1, 1, 1'b0);
    idle1();
    chk("t5_next", 32'(out0), 32'h3C9);
    ack1();

    // 6: loopback from a bench-side 12-bit PISO, acked on every completion
    for (int k = 0; k < 100; k++) begin
      logic [SIZE-1:0] w;
      w = SIZE'($urandom);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      send_bits(w, 0, SIZE - 1, 2, 1'b1);
      idle1();
      chk("t6_word0", 32'(out0), 32'(w));
      chk("t6_word1", 32'(out1), 32'(w));
      chk("t6_ovr", 32'(ovr1), 32'h0);
    end

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      cyc(1'($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 3) == 0));
    end
    idle1();
    idle1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
